// File: rtl/mem_arb.sv
// mem_arb: shares the single-ported mem_system between the I-fetch and D requesters.
// Build option MEM_ARB_RR_EN selects round-robin arbitration; otherwise D-port has priority.
module mem_arb #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rd,
  input  logic [15:0]      i_addr,
  output logic [15:0]      i_rdata,
  output logic             i_done,
  output logic             i_hit,
  input  logic             d_rd,
  input  logic             d_wr,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic [15:0]      d_rdata,
  output logic             d_done,
  output logic             d_hit,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  output logic             mem_rd,
  output logic             mem_wr,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_done,
  input  logic             mem_stall,
  input  logic             mem_hit,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e           r_state, w_state_d;
  logic [15:0]      r_addr, w_addr_d;
  logic [15:0]      r_wdata, w_wdata_d;
  logic             r_rd, w_rd_d;
  logic             r_wr, w_wr_d;
  logic             r_err, w_err_d;
  logic [CNT_W-1:0] r_req_cnt, w_req_cnt_d;
  logic [CNT_W-1:0] r_hit_cnt, w_hit_cnt_d;
  logic             w_d_req, w_d_win, w_i_fin, w_d_fin;

  assign w_d_req = d_rd | d_wr;

`ifdef MEM_ARB_RR_EN
  logic r_last_d, w_last_d_d;  // 1: most recent grant went to the D-port
  assign w_d_win = w_d_req & (~i_rd | ~r_last_d);
`else
  assign w_d_win = w_d_req;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_addr_d    = r_addr;
    w_wdata_d   = r_wdata;
    w_rd_d      = r_rd;
    w_wr_d      = r_wr;
    w_err_d     = r_err;
    w_req_cnt_d = r_req_cnt;
    w_hit_cnt_d = r_hit_cnt;
`ifdef MEM_ARB_RR_EN
    w_last_d_d  = r_last_d;
`endif
    unique case (r_state)
      StIdle: begin
        if (d_rd && d_wr) w_err_d = 1'b1;
        if (!mem_stall && w_d_win) begin
          w_state_d = StBusyD;
          w_addr_d  = d_addr;
          w_wdata_d = d_wdata;
          // A simultaneous read+write is served as a write.
          w_rd_d    = d_rd & ~d_wr;
          w_wr_d    = d_wr;
`ifdef MEM_ARB_RR_EN
          w_last_d_d = 1'b1;
`endif
        end else if (!mem_stall && i_rd) begin
          w_state_d = StBusyI;
          w_addr_d  = i_addr;
          w_wdata_d = '0;
          w_rd_d    = 1'b1;
          w_wr_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
          w_last_d_d = 1'b0;
`endif
        end
      end
      StBusyI, StBusyD: begin
        if (mem_done) begin
          w_state_d = StIdle;
          w_rd_d    = 1'b0;
          w_wr_d    = 1'b0;
          if (r_req_cnt != '1) w_req_cnt_d = r_req_cnt + 1'b1;
          if (mem_hit && (r_hit_cnt != '1)) w_hit_cnt_d = r_hit_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_err     <= 1'b0;
      r_req_cnt <= '0;
      r_hit_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_addr    <= w_addr_d;
      r_wdata   <= w_wdata_d;
      r_rd      <= w_rd_d;
      r_wr      <= w_wr_d;
      r_err     <= w_err_d;
      r_req_cnt <= w_req_cnt_d;
      r_hit_cnt <= w_hit_cnt_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) r_last_d <= 1'b0;
    else     r_last_d <= w_last_d_d;
  end
`endif

  // Completion is steered only to the granted port; the other sees zeros.
  assign w_i_fin = (r_state == StBusyI) && mem_done;
  assign w_d_fin = (r_state == StBusyD) && mem_done;

  assign i_done    = w_i_fin;
  assign i_hit     = w_i_fin & mem_hit;
  assign i_rdata   = w_i_fin ? mem_rdata : '0;
  assign d_done    = w_d_fin;
  assign d_hit     = w_d_fin & mem_hit;
  assign d_rdata   = w_d_fin ? mem_rdata : '0;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_rd    = r_rd;
  assign mem_wr    = r_wr;
  assign busy      = (r_state != StIdle);
  assign err       = r_err;
  assign req_cnt   = r_req_cnt;
  assign hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios, then randomized traffic against a mem_system model
// with a queue-based scoreboard. A second instance with 2-bit counters exercises saturation.
module tb_mem_arb;

  typedef struct packed {
    logic [15:0] data;
    logic        hit;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd, d_rd, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done, mem_stall, mem_hit;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, i_hit, d_done, d_hit, mem_rd, mem_wr, busy, err;
  logic [15:0] req_cnt, hit_cnt;
  // Outputs of the narrow-counter instance
  logic [15:0] x_i_rdata, x_d_rdata, x_mem_addr, x_mem_wdata;
  logic        x_i_done, x_i_hit, x_d_done, x_d_hit, x_mem_rd, x_mem_wr, x_busy, x_err;
  logic [1:0]  x_req_cnt, x_hit_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_req  = 0;
  int   exp_hit  = 0;
  bit   run_rand = 1'b0;
  exp_t i_q[$];
  exp_t d_q[$];
  logic [15:0] rmem [logic [15:0]];  // mem_system contents as seen by the responder
  logic [15:0] smem [logic [15:0]];  // scoreboard's view of D-port writes

`ifdef MEM_ARB_RR_EN
  localparam bit RrMode = 1'b1;
`else
  localparam bit RrMode = 1'b0;
`endif

  mem_arb #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_hit(i_hit),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_hit(d_hit),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_hit(mem_hit),
    .busy(busy), .err(err), .req_cnt(req_cnt), .hit_cnt(hit_cnt)
  );

  mem_arb #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .i_rd(i_rd), .i_addr(i_addr), .i_rdata(x_i_rdata), .i_done(x_i_done), .i_hit(x_i_hit),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(x_d_rdata),
    .d_done(x_d_done), .d_hit(x_d_hit),
    .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata), .mem_rd(x_mem_rd), .mem_wr(x_mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_hit(mem_hit),
    .busy(x_busy), .err(x_err), .req_cnt(x_req_cnt), .hit_cnt(x_hit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic hit_of(input logic [15:0] a);
    return a[0] ^ a[2];
  endfunction

  function automatic logic [15:0] init_data(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // mem_system model: hits finish in the first command cycle, misses take 2..7 cycles.
  task automatic responder();
    bit active = 1'b0;
    int unsigned wait_c = 0;
    while (run_rand) begin
      tick();
      mem_done  = 1'b0;
      mem_hit   = 1'b0;
      mem_rdata = '0;
      mem_stall = ($urandom_range(0, 3) == 0);
      if (!(mem_rd || mem_wr)) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          wait_c = hit_of(mem_addr) ? 0 : $urandom_range(1, 6);
        end
        if (wait_c == 0) begin
          mem_hit = hit_of(mem_addr);
          if (mem_wr) begin
            rmem[mem_addr] = mem_wdata;
            mem_rdata = mem_wdata;
          end else begin
            mem_rdata = rmem.exists(mem_addr) ? rmem[mem_addr] : init_data(mem_addr);
          end
          mem_done = 1'b1;
          active   = 1'b0;
        end else begin
          wait_c--;
        end
      end
    end
    mem_done  = 1'b0;
    mem_stall = 1'b0;
  endtask

  task automatic drive_i(input int n);
    logic [15:0] a;
    bit got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = {1'b0, 15'($urandom)};
      i_addr = a;
      i_rd   = 1'b1;
      i_q.push_back('{data: init_data(a), hit: hit_of(a)});
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        smp();
        if (i_done) got = 1'b1;
      end
      chk("i_done_timeout", 32'(got), 32'd1);
      tick();
      i_rd = 1'b0;
    end
  endtask

  task automatic drive_d(input int n);
    logic [15:0] a, wd, ed;
    bit wr, got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      a  = 16'h8000 | 16'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      if (wr) begin
        smem[a] = wd;
        ed = wd;
      end else begin
        ed = smem.exists(a) ? smem[a] : init_data(a);
      end
      d_addr  = a;
      d_wdata = wd;
      d_wr    = wr;
      d_rd    = ~wr;
      d_q.push_back('{data: ed, hit: hit_of(a)});
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        smp();
        if (d_done) got = 1'b1;
      end
      chk("d_done_timeout", 32'(got), 32'd1);
      tick();
      d_rd = 1'b0;
      d_wr = 1'b0;
    end
  endtask

  // Scoreboard: pops on each done pulse, and checks every grant against the arbitration rule.
  task automatic monitor();
    exp_t e;
    bit pend = 1'b0, pend_stall = 1'b0, exp_d, last_d = 1'b0, exp_wr = 1'b0;
    logic [15:0] exp_a = '0;
    while (run_rand) begin
      smp();
      chk("req_cnt", 32'(req_cnt), 32'(exp_req));
      chk("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
      if (pend) begin
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_addr", 32'(mem_addr), 32'(exp_a));
        chk("grant_wr", 32'(mem_wr), 32'(exp_wr));
        chk("grant_rd", 32'(mem_rd), 32'(!exp_wr));
      end
      if (pend_stall) chk("stall_no_grant", 32'(busy), 32'd0);
      pend = 1'b0;
      pend_stall = 1'b0;
      chk("one_done", 32'(i_done && d_done), 32'd0);
      if (i_done) begin
        chk("i_q_nonempty", 32'(i_q.size() != 0), 32'd1);
        if (i_q.size() != 0) begin
          e = i_q.pop_front();
          chk("i_rdata", 32'(i_rdata), 32'(e.data));
          chk("i_hit", 32'(i_hit), 32'(e.hit));
          exp_req++;
          if (e.hit) exp_hit++;
        end
      end else begin
        chk("i_rdata_gated", 32'(i_rdata), 32'd0);
      end
      if (d_done) begin
        chk("d_q_nonempty", 32'(d_q.size() != 0), 32'd1);
        if (d_q.size() != 0) begin
          e = d_q.pop_front();
          chk("d_rdata", 32'(d_rdata), 32'(e.data));
          chk("d_hit", 32'(d_hit), 32'(e.hit));
          exp_req++;
          if (e.hit) exp_hit++;
        end
      end else begin
        chk("d_rdata_gated", 32'(d_rdata), 32'd0);
      end
      if (!busy && (i_rd || d_rd || d_wr)) begin
        if (mem_stall) begin
          pend_stall = 1'b1;
        end else begin
          exp_d  = (d_rd || d_wr) && (!i_rd || !RrMode || !last_d);
          pend   = 1'b1;
          last_d = exp_d;
          exp_a  = exp_d ? d_addr : i_addr;
          exp_wr = exp_d && d_wr;
        end
      end
    end
  endtask

  initial begin
    bit first_i;
    rst = 1'b1;
    i_rd = 0; d_rd = 0; d_wr = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_done = 0; mem_stall = 0; mem_hit = 0;
    tick(); tick();
    smp();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req_cnt", 32'(req_cnt), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);

    // Single I-port hit with 1-cycle memory latency
    tick(); rst = 1'b0; i_rd = 1'b1; i_addr = 16'h0010;
    tick(); smp();
    chk("t1_mem_rd", 32'(mem_rd), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
    tick(); mem_done = 1; mem_hit = 1; mem_rdata = 16'hBEEF;
    smp();
    chk("t1_i_done", 32'(i_done), 32'd1);
    chk("t1_i_rdata", 32'(i_rdata), 32'hBEEF);
    chk("t1_i_hit", 32'(i_hit), 32'd1);
    chk("t1_d_done", 32'(d_done), 32'd0);
    tick(); mem_done = 0; mem_hit = 0; mem_rdata = '0; i_rd = 1'b0;
    smp();
    chk("t1_req_cnt", 32'(req_cnt), 32'd1);
    chk("t1_hit_cnt", 32'(hit_cnt), 32'd1);
    chk("t1_idle_rd", 32'(mem_rd), 32'd0);

    // I read and D write together: D first, I in the IDLE cycle after d_done
    tick(); i_rd = 1; i_addr = 16'h0030; d_wr = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
    tick(); smp();
    chk("t2_mem_wr", 32'(mem_wr), 32'd1);
    chk("t2_mem_rd", 32'(mem_rd), 32'd0);
    chk("t2_mem_addr", 32'(mem_addr), 32'h0020);
    chk("t2_mem_wdata", 32'(mem_wdata), 32'h1234);
    tick(); mem_done = 1; mem_hit = 1;
    smp();
    chk("t2_d_done", 32'(d_done), 32'd1);
    chk("t2_i_done", 32'(i_done), 32'd0);
    tick(); mem_done = 0; mem_hit = 0; d_wr = 0;
    smp();
    chk("t2_idle", 32'(busy), 32'd0);
    tick(); smp();
    chk("t2_i_grant", 32'(mem_rd), 32'd1);
    chk("t2_i_addr", 32'(mem_addr), 32'h0030);
    tick(); mem_done = 1; mem_hit = 0; mem_rdata = 16'h0F0F;
    smp();
    chk("t2_i_rdata", 32'(i_rdata), 32'h0F0F);
    chk("t2_i_hit", 32'(i_hit), 32'd0);
    tick(); mem_done = 0; mem_rdata = '0; i_rd = 0;

    // Stall blocks the grant; then a 10-cycle miss
    mem_stall = 1; d_rd = 1; d_addr = 16'h0040;
    for (int k = 0; k < 3; k++) begin
      tick(); smp();
      chk("t3_stall_busy", 32'(busy), 32'd0);
    end
    tick(); mem_stall = 0;
    smp();
    chk("t3_stall_last", 32'(mem_rd), 32'd0);
    tick(); smp();
    chk("t3_grant_rd", 32'(mem_rd), 32'd1);
    chk("t3_grant_addr", 32'(mem_addr), 32'h0040);
    for (int k = 0; k < 9; k++) begin
      tick(); smp();
      chk("t3_miss_rd_held", 32'(mem_rd), 32'd1);
      chk("t3_miss_no_done", 32'(d_done), 32'd0);
    end
    tick(); mem_done = 1; mem_hit = 0; mem_rdata = 16'h7777;
    smp();
    chk("t3_d_done", 32'(d_done), 32'd1);
    chk("t3_d_hit", 32'(d_hit), 32'd0);
    chk("t3_d_rdata", 32'(d_rdata), 32'h7777);
    tick(); mem_done = 0; mem_rdata = '0; d_rd = 0;
    smp();
    chk("t3_req_cnt", 32'(req_cnt), 32'd4);
    chk("t3_hit_cnt", 32'(hit_cnt), 32'd2);

    // Simultaneous reads after a D grant: round-robin picks I, fixed priority picks D
    first_i = RrMode;
    tick(); i_rd = 1; i_addr = 16'h0060; d_rd = 1; d_addr = 16'h0070;
    tick(); smp();
    chk("t4_first_addr", 32'(mem_addr), first_i ? 32'h0060 : 32'h0070);
    tick(); mem_done = 1; mem_hit = 1;
    smp();
    chk("t4_first_done", 32'(first_i ? i_done : d_done), 32'd1);
    tick(); mem_done = 0; mem_hit = 0;
    if (first_i) i_rd = 0; else d_rd = 0;
    tick(); smp();
    chk("t4_second_addr", 32'(mem_addr), first_i ? 32'h0070 : 32'h0060);
    tick(); mem_done = 1; mem_hit = 1;
    smp();
    chk("t4_second_done", 32'(first_i ? d_done : i_done), 32'd1);
    tick(); mem_done = 0; mem_hit = 0; i_rd = 0; d_rd = 0;

    // d_rd and d_wr together: sticky err, served as a write
    tick(); d_rd = 1; d_wr = 1; d_addr = 16'h0050; d_wdata = 16'h5555;
    tick(); smp();
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_mem_wr", 32'(mem_wr), 32'd1);
    chk("t5_mem_rd", 32'(mem_rd), 32'd0);
    chk("t5_mem_wdata", 32'(mem_wdata), 32'h5555);
    tick(); mem_done = 1; mem_hit = 1;
    smp();
    chk("t5_d_done", 32'(d_done), 32'd1);
    tick(); mem_done = 0; mem_hit = 0; d_rd = 0; d_wr = 0;
    tick(); smp();
    chk("t5_err_sticky", 32'(err), 32'd1);
    chk("t5_req_cnt", 32'(req_cnt), 32'd7);
    chk("t5_hit_cnt", 32'(hit_cnt), 32'd5);
    chk("sat_req_cnt", 32'(x_req_cnt), 32'd3);
    chk("sat_hit_cnt", 32'(x_hit_cnt), 32'd3);

    // Reset during a D write miss abandons it
    tick(); d_wr = 1; d_addr = 16'h0090; d_wdata = 16'hA0A0;
    tick(); smp();
    chk("t6_mem_wr", 32'(mem_wr), 32'd1);
    tick(); tick(); rst = 1;
    tick(); rst = 0; d_wr = 0;
    smp();
    chk("t6_mem_wr_rst", 32'(mem_wr), 32'd0);
    chk("t6_busy_rst", 32'(busy), 32'd0);
    chk("t6_err_rst", 32'(err), 32'd0);
    chk("t6_addr_rst", 32'(mem_addr), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick(); mem_done = 1; mem_hit = 1;
      smp();
      chk("t6_no_d_done", 32'(d_done), 32'd0);
      chk("t6_no_i_done", 32'(i_done), 32'd0);
    end
    tick(); mem_done = 0; mem_hit = 0;
    smp();
    chk("t6_req_cnt", 32'(req_cnt), 32'd0);
    chk("t6_hit_cnt", 32'(hit_cnt), 32'd0);

    // Randomized traffic
    tick();
    run_rand = 1'b1;
    fork
      responder();
      monitor();
      begin
        fork
          drive_i(40);
          drive_d(40);
        join
        repeat (3) tick();
        run_rand = 1'b0;
      end
    join
    smp();
    chk("rand_i_q_empty", 32'(i_q.size()), 32'd0);
    chk("rand_d_q_empty", 32'(d_q.size()), 32'd0);
    chk("rand_req_cnt", 32'(req_cnt), 32'(exp_req));
    chk("rand_hit_cnt", 32'(hit_cnt), 32'(exp_hit));
    chk("rand_sat_req", 32'(x_req_cnt), 32'(sat3(exp_req)));
    chk("rand_sat_hit", 32'(x_hit_cnt), 32'(sat3(exp_hit)));
    chk("rand_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port arbiter that shares the single-ported cache memory system (`mem_system`) between the instruction-fetch requester (I-port, read-only) and the data requester (D-port, read/write). It sits between the fetch/memory pipeline stages and `mem_system`. It serialises requests, holds the winning request on the memory interface until `Done`, and routes `DataOut`, `Done` and `CacheHit` back to the winner. It also keeps saturating hit and request counters for performance reporting.

## Interface
- `CNT_W`, default 16: width of the performance counters.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_rd`  in  1  I-port read request; held until `i_done`.
- `i_addr`  in  16  I-port address.
- `i_rdata`  out  16  I-port read data; valid when `i_done`.
- `i_done`  out  1  I-port completion, 1-cycle pulse.
- `i_hit`  out  1  I-port CacheHit; valid with `i_done`.
- `d_rd`  in  1  D-port read request; held until `d_done`.
- `d_wr`  in  1  D-port write request; held until `d_done`.
- `d_addr`  in  16  D-port address.
- `d_wdata`  in  16  D-port write data.
- `d_rdata`  out  16  D-port read data; valid when `d_done`.
- `d_done`  out  1  D-port completion, 1-cycle pulse.
- `d_hit`  out  1  D-port CacheHit; valid with `d_done`.
- `mem_addr`  out  16  to `mem_system` `Addr`.
- `mem_wdata`  out  16  to `mem_system` `DataIn`.
- `mem_rd`  out  1  to `mem_system` `Rd`.
- `mem_wr`  out  1  to `mem_system` `Wr`.
- `mem_rdata`  in  16  from `mem_system` `DataOut`.
- `mem_done`  in  1  from `mem_system` `Done`.
- `mem_stall`  in  1  from `mem_system` `Stall`.
- `mem_hit`  in  1  from `mem_system` `CacheHit`.
- `busy`  out  1  a request is outstanding on the memory interface.
- `err`  out  1  sticky: `d_rd` and `d_wr` were high together in IDLE.
- `req_cnt`  out  CNT_W  number of completed transactions, saturating.
- `hit_cnt`  out  CNT_W  number of completed hits, saturating.

## Operation
- States: IDLE, BUSY_I, BUSY_D. State, `mem_*` outputs and the counters are registered.
- In IDLE, with `mem_stall`=0, a pending request wins a grant:
  - D-port wins over I-port under fixed priority; see Configuration for round-robin.
  - The grant latches address, write data and command into `mem_addr`/`mem_wdata`/`mem_rd`/`mem_wr`.
  - The next state is BUSY_I or BUSY_D.
- In IDLE with `mem_stall`=1, no grant is made.
- In BUSY_x:
  - Latched outputs hold steady and requester inputs are ignored.
  - On `mem_done`=1, `x_done`, `x_rdata` and `x_hit` pass through combinationally in that cycle.
  - At the following edge, `mem_rd`/`mem_wr` clear and the state returns to IDLE.
- `i_done`/`d_done`/`*_hit` are gated by state, so the non-granted port always sees 0. `*_rdata` are gated the same way and read 0 when not granted.
- `d_rd`&`d_wr` both high in IDLE:
  - Sets `err`; `err` clears only on `rst`.
  - The request is granted as a write.
- On each `mem_done` in BUSY_x:
  - `req_cnt` increments.
  - `hit_cnt` increments if `mem_hit`=1.
  - Both counters saturate at all-ones.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE; `mem_addr`, `mem_wdata` and both counters 0; `mem_rd`, `mem_wr`, `busy`, `err`, `i_done`, `d_done`, `i_hit`, `d_hit` all 0.
- Arbitration costs 1 cycle: a request first visible in cycle N (IDLE, unstalled) drives `mem_rd`/`mem_wr` from cycle N+1.
- End-to-end latency = 1 + `mem_system` latency. A hit with 1-cycle mem latency gives `x_done` in cycle N+2.
- Back-to-back: the cycle after `x_done` is IDLE, and a new grant can be made there. Minimum spacing between grants is 2 cycles.
- A request dropped by the requester before its done pulse is a protocol violation and is not supported.
- `rst` asserted mid-transaction: the transaction is abandoned, all outputs return to their reset values at that edge, and no done pulse is produced.
- `mem_done` in IDLE is ignored and is not counted.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - A 1-bit last-grant register (reset value = I) is updated on each grant.
  - When both ports request in the same IDLE cycle, the port not granted last wins.
  - A single requester is granted immediately.
- `MEM_ARB_RR_EN` undefined: fixed priority, D-port over I-port; no last-grant register.

## Test plan
- Reset, then `i_rd`=1, `i_addr`=0x0010, mem hit 1 cycle later with `mem_rdata`=0xBEEF.
  - Expect `mem_rd`=1 and `mem_addr`=0x0010 in cycle 1.
  - Expect `i_done`=1, `i_rdata`=0xBEEF, `i_hit`=1 in cycle 2.
  - Expect `req_cnt`=1 and `hit_cnt`=1 after that cycle.
- `i_rd` and `d_wr` (addr 0x0020, data 0x1234) asserted together.
  - Expect D granted first, with `mem_wr`=1 and `mem_wdata`=0x1234.
  - Expect I granted in the IDLE cycle after `d_done`.
  - With RR_EN, a second simultaneous pair grants I first.
- `mem_stall`=1 for 3 cycles while `d_rd`=1: expect no grant and `busy`=0, then a grant the cycle after stall drops.
- Miss with `mem_done` 10 cycles after issue: expect `mem_rd` held for all 10 cycles, one `d_done` pulse with `d_hit`=0, `hit_cnt` unchanged, `req_cnt` +1.
- `d_rd`=`d_wr`=1 in IDLE: expect `err`=1 from the next cycle, `mem_wr`=1, `mem_rd`=0; `err` stays 1 until `rst`.
- `rst` pulsed during a BUSY_D miss: expect `mem_wr`=0 and `busy`=0 after the edge, and no `d_done` even if `mem_done` arrives later.
